// File: rtl/fpu_sched_pkg.sv
// Shared types and constants for the round-robin FPU scheduler.
package fpu_sched_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned FLG_W   = 4;
  localparam int unsigned FLG_UNF = 0;
  localparam int unsigned FLG_OVF = 1;
  localparam int unsigned FLG_ERR = 2;
  localparam int unsigned FLG_TMO = 3;

  localparam logic [WORD_W-1:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  typedef enum logic [1:0] {ADD = 2'b00, SUB = 2'b01, MUL = 2'b10, DIV = 2'b11} fpu_mode_e;

  typedef struct packed {
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    fpu_mode_e         mode;
    logic              round;
  } fpu_op_t;

  typedef struct packed {
    logic [WORD_W-1:0] y;
    logic [FLG_W-1:0]  flags;
  } fpu_rsp_t;

endpackage

// File: rtl/fpu_rr_scheduler_if.sv
// Request, response and FPU-side signals of the scheduler; master = scheduler, slave = environment.
interface fpu_rr_scheduler_if #(
  parameter int unsigned N_REQ = 4
);
  import fpu_sched_pkg::*;

  localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]        req_valid;
  logic [WORD_W*N_REQ-1:0] req_a;
  logic [WORD_W*N_REQ-1:0] req_b;
  logic [2*N_REQ-1:0]      req_mode;
  logic [N_REQ-1:0]        req_round;
  logic [N_REQ-1:0]        req_ready;

  logic                    rsp_valid;
  logic [ID_W-1:0]         rsp_id;
  logic [WORD_W-1:0]       rsp_y;
  logic [FLG_W-1:0]        rsp_flags;
  logic                    rsp_ready;

  logic                    fpu_start;
  logic [WORD_W-1:0]       fpu_a;
  logic [WORD_W-1:0]       fpu_b;
  logic [1:0]              fpu_mode;
  logic                    fpu_round;
  logic                    fpu_done;
  logic [WORD_W-1:0]       fpu_y;
  logic                    fpu_error;
  logic                    fpu_overflow;
  logic                    fpu_underflow;

  modport master (
    input  req_valid, req_a, req_b, req_mode, req_round, rsp_ready,
           fpu_done, fpu_y, fpu_error, fpu_overflow, fpu_underflow,
    output req_ready, rsp_valid, rsp_id, rsp_y, rsp_flags,
           fpu_start, fpu_a, fpu_b, fpu_mode, fpu_round
  );

  modport slave (
    output req_valid, req_a, req_b, req_mode, req_round, rsp_ready,
           fpu_done, fpu_y, fpu_error, fpu_overflow, fpu_underflow,
    input  req_ready, rsp_valid, rsp_id, rsp_y, rsp_flags,
           fpu_start, fpu_a, fpu_b, fpu_mode, fpu_round
  );

endinterface

// File: rtl/fpu_rr_scheduler_rr_grant.sv
// Round-robin priority encoder: first set request at or after ptr, wrapping to 0.
module rr_grant #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [ID_W-1:0]  idx
);

  logic            found;
  logic [ID_W-1:0] pos;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    pos    = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      pos = ID_W'((int'(ptr) + i) % int'(N_REQ));
      if (!found && req[pos]) begin
        found       = 1'b1;
        onehot[pos] = 1'b1;
        idx         = pos;
      end
    end
  end

endmodule

// File: rtl/fpu_rr_scheduler.sv
// Shares one FPU between N_REQ requesters with round-robin grants, one operation in flight.
// Optional watchdog on the FPU wait is enabled by defining FPU_SCHED_WDT_EN.
module fpu_rr_scheduler #(
  parameter int unsigned N_REQ = 4
`ifdef FPU_SCHED_WDT_EN
  , parameter int unsigned WDT_CYCLES = 16
`endif
) (
  input logic                clk,
  input logic                rst,
  fpu_rr_scheduler_if.master bus
);
  import fpu_sched_pkg::*;

  localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  id_q, id_d;
  fpu_op_t          op_q, op_d;
  fpu_rsp_t         rsp_q, rsp_d;
  logic             start_q, start_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [N_REQ-1:0] grant_oh;
  logic [ID_W-1:0]  grant_idx;
  fpu_op_t          req_op;

`ifdef FPU_SCHED_WDT_EN
  localparam int unsigned WDT_W = $clog2(WDT_CYCLES + 1);
  logic [WDT_W-1:0] wdt_q, wdt_d;
`endif

  rr_grant #(.N_REQ(N_REQ), .ID_W(ID_W)) u_grant (
    .req    (bus.req_valid),
    .ptr    (rr_ptr_q),
    .onehot (grant_oh),
    .idx    (grant_idx)
  );

  // One-hot AND-OR select of the granted requester's operation.
  always_comb begin
    req_op = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (grant_oh[i]) begin
        req_op.a     = bus.req_a[WORD_W*i +: WORD_W];
        req_op.b     = bus.req_b[WORD_W*i +: WORD_W];
        req_op.mode  = fpu_mode_e'(bus.req_mode[2*i +: 2]);
        req_op.round = bus.req_round[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    op_d        = op_q;
    rsp_d       = rsp_q;
    rsp_valid_d = rsp_valid_q;
    start_d     = 1'b0;
`ifdef FPU_SCHED_WDT_EN
    wdt_d       = wdt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|grant_oh) begin
          op_d     = req_op;
          id_d     = grant_idx;
          rr_ptr_d = ID_W'((int'(grant_idx) + 1) % int'(N_REQ));
          start_d  = 1'b1;
          state_d  = ISSUE;
        end
      end
      // fpu_done may still be high from the previous operation, so it is not looked at here.
      ISSUE: begin
`ifdef FPU_SCHED_WDT_EN
        wdt_d   = '0;
`endif
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.fpu_done) begin
          rsp_d.y              = bus.fpu_y;
          rsp_d.flags          = '0;
          rsp_d.flags[FLG_ERR] = bus.fpu_error;
          rsp_d.flags[FLG_OVF] = bus.fpu_overflow;
          rsp_d.flags[FLG_UNF] = bus.fpu_underflow;
          rsp_valid_d          = 1'b1;
          state_d              = RESP;
        end
`ifdef FPU_SCHED_WDT_EN
        else if (wdt_q == WDT_W'(WDT_CYCLES - 1)) begin
          rsp_d.y              = QNAN;
          rsp_d.flags          = '0;
          rsp_d.flags[FLG_TMO] = 1'b1;
          rsp_d.flags[FLG_ERR] = 1'b1;
          rsp_valid_d          = 1'b1;
          state_d              = RESP;
        end else begin
          wdt_d = wdt_q + WDT_W'(1);
        end
`endif
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      op_q        <= '0;
      rsp_q       <= '0;
      start_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
`ifdef FPU_SCHED_WDT_EN
      wdt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      op_q        <= op_d;
      rsp_q       <= rsp_d;
      start_q     <= start_d;
      rsp_valid_q <= rsp_valid_d;
`ifdef FPU_SCHED_WDT_EN
      wdt_q       <= wdt_d;
`endif
    end
  end

  assign bus.req_ready = (state_q == IDLE) ? grant_oh : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_y     = rsp_q.y;
  assign bus.rsp_flags = rsp_q.flags;
  assign bus.fpu_start = start_q;
  assign bus.fpu_a     = op_q.a;
  assign bus.fpu_b     = op_q.b;
  assign bus.fpu_mode  = op_q.mode;
  assign bus.fpu_round = op_q.round;

endmodule

// File: tb/tb_fpu_rr_scheduler.sv
// Directed bench for fpu_rr_scheduler with a behavioural FPU of fixed 4-cycle latency.
module tb_fpu_rr_scheduler;

  localparam int unsigned N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fpu_rr_scheduler_if #(.N_REQ(N)) bus ();

  fpu_rr_scheduler #(.N_REQ(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int starts = 0;

  // FPU model: result words are supplied per test by the stimulus below.
  logic        m_done = 1'b0;
  logic [31:0] m_y    = '0;
  logic        m_err  = 1'b0;
  logic        m_ovf  = 1'b0;
  logic        m_unf  = 1'b0;
  logic        m_hang = 1'b0;
  int          m_cnt  = 0;

  assign bus.fpu_done      = m_done;
  assign bus.fpu_y         = m_y;
  assign bus.fpu_error     = m_err;
  assign bus.fpu_overflow  = m_ovf;
  assign bus.fpu_underflow = m_unf;

  always @(posedge clk) begin
    if (bus.fpu_start) begin
      starts <= starts + 1;
      m_done <= 1'b0;
      m_cnt  <= 3;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1 && !m_hang) m_done <= 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk(tag, 64'(bus.rsp_valid), 64'd1);
  endtask

  task automatic rsp_ack(input string tag);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk(tag, 64'(bus.rsp_valid), 64'd0);
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] m, input logic r);
    bus.req_a[32*i +: 32] = a;
    bus.req_b[32*i +: 32] = b;
    bus.req_mode[2*i +: 2] = m;
    bus.req_round[i]       = r;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    chk({pfx, "_fpu_start"}, 64'(bus.fpu_start), 64'd0);
    chk({pfx, "_rsp_id"},    64'(bus.rsp_id),    64'd0);
    chk({pfx, "_rsp_y"},     64'(bus.rsp_y),     64'd0);
    chk({pfx, "_rsp_flags"}, 64'(bus.rsp_flags), 64'd0);
    chk({pfx, "_fpu_a"},     64'(bus.fpu_a),     64'd0);
    chk({pfx, "_fpu_b"},     64'(bus.fpu_b),     64'd0);
    chk({pfx, "_fpu_mode"},  64'(bus.fpu_mode),  64'd0);
    chk({pfx, "_fpu_round"}, 64'(bus.fpu_round), 64'd0);
  endtask

  logic [1:0] exp_ids [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  initial begin
    int s0;
    int seen;

    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_mode  = '0;
    bus.req_round = '0;
    bus.rsp_ready = 1'b0;

    // Reset values
    rst = 1'b1;
    repeat (2) tick();
    chk_reset_outputs("rst");
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    rst = 1'b0;

    // Requester 2: 1.0 + 1.0
    m_y = 32'h4000_0000;
    set_req(2, 32'h3F80_0000, 32'h3F80_0000, 2'b00, 1'b0);
    bus.req_valid = 4'b0100;
    #1;
    chk("t1_req_ready", 64'(bus.req_ready), 64'b0100);
    s0 = starts;
    tick();
    chk("t1_start_hi", 64'(bus.fpu_start), 64'd1);
    chk("t1_fpu_a", 64'(bus.fpu_a), 64'h3F80_0000);
    chk("t1_fpu_b", 64'(bus.fpu_b), 64'h3F80_0000);
    chk("t1_ready_issue", 64'(bus.req_ready), 64'd0);
    bus.req_valid = '0;
    tick();
    chk("t1_start_lo", 64'(bus.fpu_start), 64'd0);
    wait_rsp("t1_rsp_valid");
    chk("t1_rsp_id", 64'(bus.rsp_id), 64'd2);
    chk("t1_rsp_y", 64'(bus.rsp_y), 64'h4000_0000);
    chk("t1_rsp_flags", 64'(bus.rsp_flags), 64'd0);
    chk("t1_one_start", 64'(starts - s0), 64'd1);
    rsp_ack("t1_ack");

    // All requesters valid from rr_ptr=0: grants 0,1,2,3,0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_y = 32'h1234_5678;
    for (int i = 0; i < 4; i++) set_req(i, 32'h4000_0000 | 32'(i), 32'h0, 2'b10, 1'b0);
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_rsp($sformatf("t2_rsp_valid_%0d", k));
      chk($sformatf("t2_rsp_id_%0d", k), 64'(bus.rsp_id), 64'(exp_ids[k]));
      chk($sformatf("t2_fpu_a_%0d", k), 64'(bus.fpu_a), 64'h4000_0000 | 64'(exp_ids[k]));
      rsp_ack($sformatf("t2_ack_%0d", k));
    end

    // Consumer stalls for 10 cycles: next grant is requester 1
    wait_rsp("t3_rsp_valid");
    s0 = starts;
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("t3_ready_%0d", c), 64'(bus.req_ready), 64'd0);
      tick();
    end
    chk("t3_rsp_valid_held", 64'(bus.rsp_valid), 64'd1);
    chk("t3_rsp_id_held", 64'(bus.rsp_id), 64'd1);
    chk("t3_rsp_y_held", 64'(bus.rsp_y), 64'h1234_5678);
    chk("t3_no_start", 64'(starts - s0), 64'd0);
    bus.req_valid = '0;
    rsp_ack("t3_ack");

    // Requester 1: 1.0 / 0.0 -> +inf with overflow
    m_y   = 32'h7F80_0000;
    m_ovf = 1'b1;
    set_req(1, 32'h3F80_0000, 32'h0000_0000, 2'b11, 1'b0);
    bus.req_valid = 4'b0010;
    tick();
    bus.req_valid = '0;
    wait_rsp("t4_rsp_valid");
    chk("t4_rsp_id", 64'(bus.rsp_id), 64'd1);
    chk("t4_fpu_mode", 64'(bus.fpu_mode), 64'b11);
    chk("t4_rsp_y", 64'(bus.rsp_y), 64'h7F80_0000);
    chk("t4_rsp_flags", 64'(bus.rsp_flags), 64'b0010);
    rsp_ack("t4_ack");
    m_ovf = 1'b0;

    // FPU never signals done
    m_hang = 1'b1;
    set_req(0, 32'h3F80_0000, 32'h3F80_0000, 2'b00, 1'b0);
    bus.req_valid = 4'b0001;
    tick();
    bus.req_valid = '0;
`ifdef FPU_SCHED_WDT_EN
    wait_rsp("t5_rsp_valid");
    chk("t5_rsp_id", 64'(bus.rsp_id), 64'd0);
    chk("t5_rsp_y", 64'(bus.rsp_y), 64'h7FC0_0000);
    chk("t5_rsp_flags", 64'(bus.rsp_flags), 64'b1100);
    rsp_ack("t5_ack");
`else
    seen = 0;
    repeat (40) begin
      tick();
      if (bus.rsp_valid === 1'b1) seen++;
    end
    chk("t5_no_rsp", 64'(seen), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
`endif
    m_hang = 1'b0;

    // Reset during WAIT: stale done must not produce a response
    m_y = 32'h3F80_0000;
    set_req(1, 32'h4040_0000, 32'h4080_0000, 2'b01, 1'b1);
    bus.req_valid = 4'b0010;
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_outputs("t6");
    seen = 0;
    repeat (8) begin
      tick();
      if (bus.rsp_valid === 1'b1) seen++;
    end
    chk("t6_no_stale_rsp", 64'(seen), 64'd0);
    bus.req_valid = 4'b1001;
    #1;
    chk("t6_ptr_zero_grant", 64'(bus.req_ready), 64'b0001);
    tick();
    bus.req_valid = '0;
    wait_rsp("t6_rsp_valid");
    chk("t6_rsp_id", 64'(bus.rsp_id), 64'd0);
    rsp_ack("t6_ack");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

endmodule
